bin_to_bcd_seq: RTL and testbench

Sequential double-dabble converter between the output register and the seven-segment digit decoders. It replaces the combinational divide/modulo path.
- Takes the latched 8-bit output value and produces packed BCD hundreds/tens/units plus leading-zero blanking flags.
- Shifts one bit per clock, so no divider logic is needed.
- Holds the last result stable until a new conversion completes, so the displays never flicker.

---
 rtl/bin_to_bcd_seq_if.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 138 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Conversion request/result bundle for bin_to_bcd_seq.
// master drives bin/start; slave (the converter) drives the result and status.
interface bin_to_bcd_seq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic [WIDTH-1:0]    bin;
  logic                start;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   blank;
  logic                neg;
  logic                busy;
  logic                done;

  modport master (output bin, start, input bcd, blank, neg, busy, done);
  modport slave  (input bin, start, output bcd, blank, neg, busy, done);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with leading-zero blanking and a one-deep request queue.
// Define SIGNED_BCD_EN to treat bin as two's complement and report the sign on neg.
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic             clk,
  input logic             rst,
  bin_to_bcd_seq_if.slave bus
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  logic [SW-1:0]       scratch;
  logic [WIDTH-1:0]    shreg;
  logic [CW-1:0]       cnt;
  logic                sign_r;
  logic                pending;
  logic [WIDTH-1:0]    pend_buf;
  logic                pend_sign;
  logic [SW-1:0]       bcd_r;
  logic [DIGITS-1:0]   blank_r;
  logic                neg_r;
  logic                busy_r;
  logic                done_r;

  logic [WIDTH-1:0]    mag_bin;
  logic                sign_bin;
  logic [SW-1:0]       adj;
  logic [SW+WIDTH-1:0] work_nxt;
  logic [DIGITS-1:0]   blank_nxt;
  logic                higher_zero;

`ifdef SIGNED_BCD_EN
  assign sign_bin = bus.bin[WIDTH-1];
  assign mag_bin  = sign_bin ? (~bus.bin + WIDTH'(1)) : bus.bin;
`else
  assign sign_bin = 1'b0;
  assign mag_bin  = bus.bin;
`endif

  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    work_nxt = {adj, shreg} << 1;
  end

  // Walk from the top digit down; a digit blanks only while everything above it is zero.
  always_comb begin
    blank_nxt   = '0;
    higher_zero = 1'b1;
    for (int unsigned j = 1; j < DIGITS; j++) begin
      higher_zero = higher_zero & (scratch[4*(DIGITS-j) +: 4] == 4'd0);
      blank_nxt[DIGITS-j] = higher_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      scratch   <= '0;
      shreg     <= '0;
      cnt       <= '0;
      sign_r    <= 1'b0;
      pending   <= 1'b0;
      pend_buf  <= '0;
      pend_sign <= 1'b0;
      bcd_r     <= '0;
      blank_r   <= ~DIGITS'(1);
      neg_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.start && state != IDLE) begin
        pending   <= 1'b1;
        pend_buf  <= mag_bin;
        pend_sign <= sign_bin;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg   <= mag_bin;
            sign_r  <= sign_bin;
            scratch <= '0;
            cnt     <= '0;
            busy_r  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= work_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1))
            state <= DONE;
        end
        DONE: begin
          bcd_r   <= scratch;
          blank_r <= blank_nxt;
          neg_r   <= sign_r;
          done_r  <= 1'b1;
          scratch <= '0;
          cnt     <= '0;
          // A start arriving now is newer than anything queued, so it wins the reload.
          if (bus.start) begin
            shreg   <= mag_bin;
            sign_r  <= sign_bin;
            pending <= 1'b0;
            state   <= SHIFT;
          end else if (pending) begin
            shreg   <= pend_buf;
            sign_r  <= pend_sign;
            pending <= 1'b0;
            state   <= SHIFT;
          end else begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bcd   = bcd_r;
  assign bus.blank = blank_r;
  assign bus.neg   = neg_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results, a negedge monitor pops them on done.
module tb_bin_to_bcd_seq;

  typedef struct {
    logic [11:0] bcd;
    logic [2:0]  blank;
    logic        neg;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sq[$];
  exp_t m_e;

  bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bif ();

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [11:0] b, input logic [2:0] bl, input logic n, input int due);
    exp_t e;
    e.bcd = b; e.blank = bl; e.neg = n; e.due = due;
    return e;
  endfunction

  function automatic exp_t model(input logic [7:0] v, input int due);
    exp_t e;
    logic [7:0] mag;
    int h, t, u;
    mag = v;
    e.neg = 1'b0;
`ifdef SIGNED_BCD_EN
    if (v[7]) begin
      mag = 8'd0 - v;
      e.neg = 1'b1;
    end
`endif
    h = int'(mag) / 100;
    t = (int'(mag) / 10) % 10;
    u = int'(mag) % 10;
    e.bcd   = {h[3:0], t[3:0], u[3:0]};
    e.blank = {h == 0, (h == 0) && (t == 0), 1'b0};
    e.due   = due;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && bif.done === 1'b1) begin
      if (sq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 bcd=%0h expected no result (cycle %0d)", bif.bcd, cyc);
      end else begin
        m_e = sq.pop_front();
        check("bcd", 32'(bif.bcd), 32'(m_e.bcd));
        check("blank", 32'(bif.blank), 32'(m_e.blank));
        check("neg", 32'(bif.neg), 32'(m_e.neg));
        check("latency", cyc, m_e.due);
      end
    end
  end

  // One-cycle start; e returns the edge index at which the DUT sampled it.
  task automatic pulse(input logic [7:0] v, output int e);
    @(negedge clk);
    bif.bin   = v;
    bif.start = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    @(negedge clk);
    bif.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sq.size() != 0 || bif.busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sq.size() != 0 || bif.busy !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got busy=%0b pending_results=%0d expected idle within %0d cycles", bif.busy, sq.size(), budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e, e2;
    logic busy_gap;
    logic [7:0]  sv_bin [3];
    logic [11:0] sv_bcd [3];
    logic [2:0]  sv_bl  [3];
    logic        sv_neg [3];

    bif.bin   = '0;
    bif.start = 1'b0;
    rst       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bcd", 32'(bif.bcd), 32'h000);
    check("rst_blank", 32'(bif.blank), 32'b110);
    check("rst_busy", 32'(bif.busy), 0);
    check("rst_done", 32'(bif.done), 0);
    check("rst_neg", 32'(bif.neg), 0);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("idle_busy", 32'(bif.busy), 0);
    check("idle_bcd", 32'(bif.bcd), 32'h000);
    check("idle_blank", 32'(bif.blank), 32'b110);

    // Single conversions
    pulse(8'd255, e);
`ifdef SIGNED_BCD_EN
    sq.push_back(mk(12'h001, 3'b110, 1'b1, e + 9));
`else
    sq.push_back(mk(12'h255, 3'b000, 1'b0, e + 9));
`endif
    check("busy_after_start", 32'(bif.busy), 1);
    wait_idle(30);
    pulse(8'd42, e);
    sq.push_back(mk(12'h042, 3'b100, 1'b0, e + 9));
    repeat (4) @(negedge clk);
`ifdef SIGNED_BCD_EN
    check("hold_bcd", 32'(bif.bcd), 32'h001);
`else
    check("hold_bcd", 32'(bif.bcd), 32'h255);
`endif
    wait_idle(30);
    pulse(8'd0, e);
    sq.push_back(mk(12'h000, 3'b110, 1'b0, e + 9));
    wait_idle(30);

    // Queued starts: 17 is overwritten by 99 before the first conversion finishes
    pulse(8'd200, e);
`ifdef SIGNED_BCD_EN
    sq.push_back(mk(12'h056, 3'b100, 1'b1, e + 9));
`else
    sq.push_back(mk(12'h200, 3'b000, 1'b0, e + 9));
`endif
    sq.push_back(mk(12'h099, 3'b100, 1'b0, e + 18));
    @(posedge clk);
    pulse(8'd17, e2);
    @(posedge clk);
    pulse(8'd99, e2);
    busy_gap = 1'b0;
    while (cyc < e + 18) begin
      if (bif.busy !== 1'b1) busy_gap = 1'b1;
      @(negedge clk);
    end
    check("busy_continuous", 32'(busy_gap), 0);
    wait_idle(30);

    // Reset mid-conversion aborts with no done pulse
    pulse(8'd123, e);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sq.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("abort_bcd", 32'(bif.bcd), 32'h000);
    check("abort_busy", 32'(bif.busy), 0);
    check("abort_blank", 32'(bif.blank), 32'b110);
    repeat (12) @(negedge clk);
    check("abort_still_idle", 32'(bif.busy), 0);
    pulse(8'd123, e);
    sq.push_back(mk(12'h123, 3'b000, 1'b0, e + 9));
    wait_idle(30);

    // Sign handling
    sv_bin[0] = 8'hFF; sv_bin[1] = 8'h80; sv_bin[2] = 8'h7F;
`ifdef SIGNED_BCD_EN
    sv_bcd[0] = 12'h001; sv_bl[0] = 3'b110; sv_neg[0] = 1'b1;
    sv_bcd[1] = 12'h128; sv_bl[1] = 3'b000; sv_neg[1] = 1'b1;
`else
    sv_bcd[0] = 12'h255; sv_bl[0] = 3'b000; sv_neg[0] = 1'b0;
    sv_bcd[1] = 12'h128; sv_bl[1] = 3'b000; sv_neg[1] = 1'b0;
`endif
    sv_bcd[2] = 12'h127; sv_bl[2] = 3'b000; sv_neg[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse(sv_bin[i], e);
      sq.push_back(mk(sv_bcd[i], sv_bl[i], sv_neg[i], e + 9));
      wait_idle(30);
    end

    // Full sweep, one conversion at a time
    for (int v = 0; v < 256; v++) begin
      pulse(8'(v), e);
      sq.push_back(model(8'(v), e + 9));
      wait_idle(30);
    end

    repeat (12) @(negedge clk);
    check("leftover_results", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
